// File: rtl/inst_fetch.sv
// Instruction fetch stage: launches word reads at the PC register's output and buffers
// {pc, instruction, fault} entries in a DEPTH-entry FIFO. Optional macro: IFETCH_ALIGN_CHECK_EN.
module inst_fetch #(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    pc_in,
  output logic                           pc_ena,
  input  logic                           flush,
  output logic                           imem_req,
  output logic [31:0]                    imem_addr,
  input  logic                           imem_ack,
  input  logic [31:0]                    imem_rdata,
  output logic                           inst_valid,
  input  logic                           inst_ready,
  output logic [31:0]                    inst_out,
  output logic [31:0]                    inst_pc,
  output logic                           inst_fault,
  output logic [1:0]                     dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]     dbg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int CN = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
`ifdef IFETCH_ALIGN_CHECK_EN
    , S_FAULT = 2'd3
`endif
  } state_t;

  state_t          state;
  state_t          launch_state;
  logic [31:0]     req_pc;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [31:0]     mem_data [DEPTH];
  logic [31:0]     mem_pc   [DEPTH];
  logic            wr;
  logic            rd;
  logic            launch;
  logic [31:0]     wr_data;
  logic [CN-1:0]   cnt_next;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic            mem_fault [DEPTH];
  logic            launch_fault;
  logic            wr_fault;
`endif

  // Handshakes: imem_req/imem_addr hold until a cycle with imem_ack=1 completes the read;
  // a FIFO entry moves to decode in a cycle where inst_valid=1 and inst_ready=1.
  assign rd = inst_valid & inst_ready;

  always_comb begin
    wr      = 1'b0;
    wr_data = imem_rdata;
`ifdef IFETCH_ALIGN_CHECK_EN
    wr_fault = 1'b0;
`endif
    if (!flush) begin
      if (state == S_WAIT && imem_ack) wr = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
      if (state == S_FAULT) begin
        wr       = 1'b1;
        wr_data  = 32'h0;
        wr_fault = 1'b1;
      end
`endif
    end
    cnt_next = {1'b0, count} + CN'(wr) - CN'(rd);
    launch   = 1'b0;
    if (!flush && !reset && (cnt_next < CN'(DEPTH))) begin
      case (state)
        S_IDLE:  launch = 1'b1;
        S_WAIT:  launch = imem_ack;
`ifdef IFETCH_ALIGN_CHECK_EN
        S_FAULT: launch = 1'b1;
`endif
        default: launch = 1'b0;
      endcase
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    launch_fault = launch & (pc_in[1:0] != 2'b00);
    launch_state = launch_fault ? S_FAULT : S_WAIT;
`else
    launch_state = S_WAIT;
`endif
  end

  assign pc_ena     = launch;
  assign imem_addr  = req_pc;
  assign inst_valid = (count != '0);
  assign inst_out   = mem_data[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
  assign dbg_state  = state;
  assign dbg_count  = count;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign inst_fault = mem_fault[rd_ptr];
`else
  assign inst_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      req_pc   <= 32'h0;
      imem_req <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= 32'h0;
        mem_pc[i]    <= 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
        mem_fault[i] <= 1'b0;
`endif
      end
    end else begin
      if (launch) req_pc <= pc_in;

      // A misaligned launch never reaches memory; otherwise the request drops on ack.
      if (launch) begin
`ifdef IFETCH_ALIGN_CHECK_EN
        imem_req <= ~launch_fault;
`else
        imem_req <= 1'b1;
`endif
      end else if (state == S_WAIT || state == S_DROP) begin
        imem_req <= ~imem_ack;
      end else begin
        imem_req <= 1'b0;
      end

      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr) begin
          mem_data[wr_ptr]  <= wr_data;
          mem_pc[wr_ptr]    <= req_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
          mem_fault[wr_ptr] <= wr_fault;
`endif
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (rd) rd_ptr <= rd_ptr + AW'(1);
        count <= cnt_next[CW-1:0];
      end

      case (state)
        S_IDLE: if (launch) state <= launch_state;
        S_WAIT: begin
          if (flush)         state <= imem_ack ? S_IDLE : S_DROP;
          else if (imem_ack) state <= launch ? launch_state : S_IDLE;
        end
        S_DROP: if (imem_ack) state <= S_IDLE;
`ifdef IFETCH_ALIGN_CHECK_EN
        S_FAULT: state <= launch ? launch_state : S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: PC register and memory models, a scoreboard queue
// checked by a monitor at each accepted head entry, and inline protocol checks.
module tb_inst_fetch;
  localparam int DEPTH = 2;

  logic                          clk;
  logic                          reset;
  logic [31:0]                   pc_in;
  logic                          pc_ena;
  logic                          flush;
  logic                          imem_req;
  logic [31:0]                   imem_addr;
  logic                          imem_ack;
  logic [31:0]                   imem_rdata;
  logic                          inst_valid;
  logic                          inst_ready;
  logic [31:0]                   inst_out;
  logic [31:0]                   inst_pc;
  logic                          inst_fault;
  logic [1:0]                    dbg_state;
  logic [$clog2(DEPTH+1)-1:0]    dbg_count;

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_ena(pc_ena), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // Scoreboard entry: {fault, pc, instruction}
  logic [64:0] exp_q[$];
  int          n_pass;
  int          n_total;
  int          mem_delay;
  int          mem_wait;
  logic        prev_req;
  logic        ena_s;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] data, input logic fault);
    exp_q.push_back({fault, pc, data});
  endtask

  // Main process sits at posedge+1; half() moves to the negedge and samples pc_ena,
  // adv() moves to the next posedge+1 and steps the PC register model.
  task automatic half();
    @(negedge clk);
    ena_s = pc_ena;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (ena_s) pc_in = pc_in + 32'd4;
  endtask

  // ---------------- memory model ----------------
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    mem_wait   = 0;
    prev_req   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!imem_req) begin
        mem_wait = 0;
        imem_ack = 1'b0;
      end else begin
        if (!prev_req || imem_ack) mem_wait = 0;
        else mem_wait = mem_wait + 1;
        imem_ack = (mem_wait == mem_delay);
      end
      prev_req   = imem_req;
      imem_rdata = 32'hE000_0000 | imem_addr;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!reset) check("count_bound", 32'(dbg_count <= DEPTH), 32'd1);
      if (!reset && !flush && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_entry: got pc %h inst %h expected none", inst_pc, inst_out);
        end else begin
          e = exp_q.pop_front();
          check("head_pc", inst_pc, e[63:32]);
          check("head_inst", inst_out, e[31:0]);
          check("head_fault", 32'(inst_fault), 32'(e[64]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_pass     = 0;
    n_total    = 0;
    reset      = 1'b1;
    pc_in      = 32'h0;
    flush      = 1'b0;
    inst_ready = 1'b0;
    mem_delay  = 0;
    ena_s      = 1'b0;

    @(negedge clk);
    check("por_req", 32'(imem_req), 32'd0);
    check("por_addr", imem_addr, 32'h0);
    check("por_valid", 32'(inst_valid), 32'd0);
    check("por_out", inst_out, 32'h0);
    check("por_pc", inst_pc, 32'h0);
    check("por_fault", 32'(inst_fault), 32'd0);
    check("por_ena", 32'(pc_ena), 32'd0);
    check("por_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Backpressure fill: exactly two launches, first entry visible two cycles after launch
    push_exp(32'h0, 32'hE000_0000, 1'b0);
    push_exp(32'h4, 32'hE000_0004, 1'b0);
    half(); check("first_launch", 32'(pc_ena), 32'd1); check("c0_req", 32'(imem_req), 32'd0); adv();
    half(); check("c1_ena", 32'(pc_ena), 32'd1); check("c1_req", 32'(imem_req), 32'd1);
            check("c1_addr", imem_addr, 32'h0); check("c1_valid", 32'(inst_valid), 32'd0); adv();
    half(); check("fill_stop", 32'(pc_ena), 32'd0); check("latency_valid", 32'(inst_valid), 32'd1);
            check("c2_addr", imem_addr, 32'h4); adv();
    half(); check("c3_ena", 32'(pc_ena), 32'd0); check("c3_req", 32'(imem_req), 32'd0); adv();
    half(); check("c4_ena", 32'(pc_ena), 32'd0); check("c4_count", 32'(dbg_count), 32'd2); adv();
    inst_ready = 1'b1;

    // Zero-wait stream at one instruction per cycle
    push_exp(32'h08, 32'hE000_0008, 1'b0);
    push_exp(32'h0C, 32'hE000_000C, 1'b0);
    push_exp(32'h10, 32'hE000_0010, 1'b0);
    push_exp(32'h14, 32'hE000_0014, 1'b0);
    push_exp(32'h18, 32'hE000_0018, 1'b0);
    for (int i = 0; i < 5; i++) begin
      half();
      check("stream_ena", 32'(pc_ena), 32'd1);
      check("stream_valid", 32'(inst_valid), 32'd1);
      if (i == 4) mem_delay = 3;
      adv();
    end

    // Slow memory: request for 0x18 held, no launches until its ack
    for (int i = 0; i < 3; i++) begin
      half();
      check("slow_ena", 32'(pc_ena), 32'd0);
      check("slow_req", 32'(imem_req), 32'd1);
      check("slow_addr", imem_addr, 32'h18);
      if (i == 2) check("slow_empty", 32'(inst_valid), 32'd0);
      adv();
    end
    half(); check("slow_relaunch", 32'(pc_ena), 32'd1); check("slow_ack_addr", imem_addr, 32'h18); adv();
    half(); check("slow_valid", 32'(inst_valid), 32'd1); check("slow_next_addr", imem_addr, 32'h1C); adv();

    // Reset in the middle of the request for 0x1C
    reset = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_out", inst_out, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_ena", 32'(pc_ena), 32'd0);
    half(); check("rst_ena_neg", 32'(pc_ena), 32'd0); adv();
    reset     = 1'b0;
    pc_in     = 32'h10;
    mem_delay = 3;

    // Flush while fetching 0x10, redirect to 0x100
    half(); check("post_rst_launch", 32'(pc_ena), 32'd1); check("post_rst_req", 32'(imem_req), 32'd0); adv();
    flush = 1'b1;
    half(); check("flush_req", 32'(imem_req), 32'd1); check("flush_addr", imem_addr, 32'h10);
            check("flush_ena", 32'(pc_ena), 32'd0); adv();
    flush = 1'b0;
    pc_in = 32'h100;
    for (int i = 0; i < 2; i++) begin
      half();
      check("drop_req", 32'(imem_req), 32'd1);
      check("drop_addr", imem_addr, 32'h10);
      check("drop_ena", 32'(pc_ena), 32'd0);
      adv();
    end
    half(); check("drop_ack_no_launch", 32'(pc_ena), 32'd0); check("drop_ack_req", 32'(imem_req), 32'd1);
            mem_delay = 0; adv();
    push_exp(32'h100, 32'hE000_0100, 1'b0);
    push_exp(32'h104, 32'hE000_0104, 1'b0);
    half(); check("redir_launch", 32'(pc_ena), 32'd1); check("redir_idle_req", 32'(imem_req), 32'd0); adv();
    half(); check("redir_ena2", 32'(pc_ena), 32'd1); check("redir_addr", imem_addr, 32'h100);
            check("redir_valid0", 32'(inst_valid), 32'd0); adv();
    half(); check("redir_valid1", 32'(inst_valid), 32'd1); adv();
    half(); check("redir_ena_e8", 32'(pc_ena), 32'd1); adv();
    flush = 1'b1;
    half(); check("flush2_ena", 32'(pc_ena), 32'd0); adv();
    for (int i = 0; i < 2; i++) begin
      half();
      check("flush_hold_valid", 32'(inst_valid), 32'd0);
      check("flush_hold_req", 32'(imem_req), 32'd0);
      check("flush_hold_ena", 32'(pc_ena), 32'd0);
      adv();
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Misaligned PCs produce fault entries without touching memory
    push_exp(32'h6, 32'h0, 1'b1);
    push_exp(32'hA, 32'h0, 1'b1);
    inst_ready = 1'b0;
    pc_in      = 32'h6;
    flush      = 1'b0;
    half(); check("fault_launch", 32'(pc_ena), 32'd1); adv();
    half(); check("fault_noreq", 32'(imem_req), 32'd0); check("fault_ena", 32'(pc_ena), 32'd1);
            check("fault_state", 32'(dbg_state), 32'd3); adv();
    half(); check("fault_full_ena", 32'(pc_ena), 32'd0); check("fault_noreq2", 32'(imem_req), 32'd0); adv();
    inst_ready = 1'b1;
    half(); adv();
    half(); adv();
    flush = 1'b1;
    half(); adv();
    half(); check("fault_flush_valid", 32'(inst_valid), 32'd0); adv();
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly downstream of the PC register. It samples the PC register's output and issues word reads to instruction memory over a req/ack handshake. Returned instructions, tagged with their PC, are buffered in a small FIFO for the decode stage. It drives the PC register's enable so the PC advances only when a fetch is launched, and supports a synchronous flush for redirects.

## Interface
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `pc_in` in 32: current PC from the PC register's `out`.
- `pc_ena` out 1: enable to the PC register; high means `pc_in` is consumed this cycle.
- `flush` in 1: synchronous redirect; discards buffered and in-flight fetches.
- `imem_req` out 1: memory read request.
- `imem_addr` out 32: request address.
- `imem_ack` in 1: memory response strobe; meaningful only while `imem_req`=1.
- `imem_rdata` in 32: read data, valid with `imem_ack`.
- `inst_valid` out 1: FIFO head valid.
- `inst_ready` in 1: decode accepts head.
- `inst_out` out 32: head instruction.
- `inst_pc` out 32: head PC.
- `inst_fault` out 1: head entry is a misaligned-fetch fault.

## Operation
- States: IDLE, WAIT (request outstanding), DROP (flushed request outstanding), FAULT (macro only).
- `count` = FIFO occupancy, 0..DEPTH. `wr` = accepted response this cycle; `rd` = `inst_valid & inst_ready`; `cnt_next` = `count + wr - rd`.
- Launch condition: (IDLE, or WAIT with `imem_ack`=1), `flush`=0, `reset`=0, and `cnt_next < DEPTH`. This reserves one slot for the outstanding request.
- On launch:
  - `pc_ena`=1 (combinational).
  - `pc_in` latched into `req_pc`.
  - Next state WAIT.
- No launch: `pc_ena`=0.
- WAIT:
  - `imem_req`=1 and `imem_addr`=`req_pc`, both held stable until `imem_ack`.
  - On ack, {`req_pc`, `imem_rdata`, fault=0} is written to the FIFO tail.
  - Next state is WAIT if a new launch occurs, else IDLE.
- Flush has priority over everything:
  - `count` is cleared and `rd` is ignored.
  - IDLE → IDLE, no launch.
  - WAIT without ack → DROP.
  - WAIT with ack → data discarded, → IDLE.
  - DROP → DROP.
- DROP: `imem_req` held high with the same address; ack data is discarded, then → IDLE. No launch in the ack cycle.
- FIFO:
  - Pop on `rd`.
  - Write and pop in the same cycle are both honoured.
  - Head outputs are registered from the FIFO array; `inst_out`/`inst_pc`/`inst_fault` are don't-care when `inst_valid`=0.
  - Pointers wrap modulo DEPTH.
  - Overflow cannot occur by construction; the bench asserts `count` ≤ DEPTH.

## Timing
- Reset values:
  - State IDLE, `count` 0.
  - `imem_req` 0, `imem_addr` 0.
  - `inst_valid` 0, `inst_out` 0, `inst_pc` 0, `inst_fault` 0.
  - `pc_ena` forced 0 while `reset`=1.
- Reset mid-request abandons the request; the memory must tolerate `imem_req` dropping.
- Latency with zero-wait memory:
  - Launch at cycle N.
  - `imem_req` high at N+1, ack at N+1.
  - `inst_valid` high at N+2.
- Throughput: one instruction per cycle with ack every cycle and `inst_ready`=1.
- With `inst_ready`=0, launches stop once `count` plus the outstanding request reaches DEPTH.
- `imem_ack` while `imem_req`=0 is ignored.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - A launch with `pc_in[1:0]`≠0 enters FAULT instead of WAIT.
  - No memory request is issued.
  - Next cycle, the entry {`req_pc`, 32'h0, fault=1} is written (it counts as `wr`) and normal launch rules apply from FAULT.
  - Flush in FAULT discards the entry → IDLE.
- Undefined:
  - No FAULT state.
  - `pc_in` passed unmodified to `imem_addr`.
  - `inst_fault` constant 0.

## Test plan
- Reset asserted mid-WAIT → all outputs at reset values immediately; after release, first launch at first clean edge with `pc_ena`=1.
- Zero-wait memory, `inst_ready`=1, PC 0,4,8,… → `inst_valid` 2 cycles after first `pc_ena`; `inst_pc`/`inst_out` pairs in order at one per cycle.
- `inst_ready`=0, DEPTH=2 → exactly 2 launches, then `pc_ena`=0; raising `inst_ready` resumes with no lost or duplicated PC.
- Memory ack delayed 3 cycles → `imem_addr` stable, `pc_ena`=0 through the wait; the ack cycle relaunches `pc_in`.
- Flush during WAIT (addr 0x10), PC redirected to 0x100 → data for 0x10 never appears; `imem_req` stays high until ack; first delivered `inst_pc`=0x100.
- With `IFETCH_ALIGN_CHECK_EN`, `pc_in`=0x6 → no `imem_req`; entry `inst_pc`=0x6, `inst_out`=0, `inst_fault`=1.
